// File: rtl/alu_pkg.sv
// Shared constants and decode types for the RV32I execute-stage ALU.
package alu_pkg;

  localparam int XLEN   = 32;
  localparam int SHAMTW = 5;

  // funct3 field codes
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // funct7 field codes
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  // full {funct7, funct3} selector codes
  localparam logic [9:0] SEL_ADD  = {F7_BASE, F3_ADD};
  localparam logic [9:0] SEL_SUB  = {F7_ALT,  F3_ADD};
  localparam logic [9:0] SEL_SLL  = {F7_BASE, F3_SLL};
  localparam logic [9:0] SEL_SLT  = {F7_BASE, F3_SLT};
  localparam logic [9:0] SEL_SLTU = {F7_BASE, F3_SLTU};
  localparam logic [9:0] SEL_XOR  = {F7_BASE, F3_XOR};
  localparam logic [9:0] SEL_SRL  = {F7_BASE, F3_SRL};
  localparam logic [9:0] SEL_SRA  = {F7_ALT,  F3_SRL};
  localparam logic [9:0] SEL_OR   = {F7_BASE, F3_OR};
  localparam logic [9:0] SEL_AND  = {F7_BASE, F3_AND};

  // decoded operation; OP_ILL covers every unlisted selector
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
    OP_XOR, OP_SRL, OP_SRA, OP_OR,  OP_AND, OP_ILL
  } alu_op_e;

  // map a raw selector onto the decoded operation
  function automatic alu_op_e decode_sel(input logic [9:0] sel);
    case (sel)
      SEL_ADD:  decode_sel = OP_ADD;
      SEL_SUB:  decode_sel = OP_SUB;
      SEL_SLL:  decode_sel = OP_SLL;
      SEL_SLT:  decode_sel = OP_SLT;
      SEL_SLTU: decode_sel = OP_SLTU;
      SEL_XOR:  decode_sel = OP_XOR;
      SEL_SRL:  decode_sel = OP_SRL;
      SEL_SRA:  decode_sel = OP_SRA;
      SEL_OR:   decode_sel = OP_OR;
      SEL_AND:  decode_sel = OP_AND;
      default:  decode_sel = OP_ILL;
    endcase
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Log-stage barrel shifter serving SLL, SRL and SRA. Left shifts are done by
// bit-reversing around a single right-shift core.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]   data,
  input  logic [SHAMTW-1:0] shamt,
  input  logic              dir,    // 1 = right, 0 = left
  input  logic              arith,  // sign-fill on right shifts
  output logic [XLEN-1:0]   result
);

  logic [SHAMTW:0][XLEN-1:0] stg;
  logic [XLEN-1:0]           data_rev;
  logic [XLEN-1:0]           core_rev;
  logic                      fill;

  // sign fill only applies to arithmetic right shifts
  assign fill = dir & arith & data[XLEN-1];

  for (genvar i = 0; i < XLEN; i++) begin : g_rev
    assign data_rev[i] = data[XLEN-1-i];
    assign core_rev[i] = stg[SHAMTW][XLEN-1-i];
  end

  assign stg[0] = dir ? data : data_rev;

  // stage k shifts right by 2^k when shamt[k] is set
  for (genvar k = 0; k < SHAMTW; k++) begin : g_stage
    localparam int SH = 1 << k;
    assign stg[k+1] = shamt[k] ? {{SH{fill}}, stg[k][XLEN-1:SH]} : stg[k];
  end

  assign result = dir ? stg[SHAMTW] : core_rev;

endmodule

// File: rtl/alu.sv
// RV32I integer ALU: shared add/sub, logic ops, barrel shifter, result mux
// and zero flag. Purely combinational; reset only masks the outputs.
module alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] in0,
  input  logic [XLEN-1:0] in1,
  input  logic [9:0]      selector,
  output logic [XLEN-1:0] out0,
  output logic            zero
);

  alu_op_e         op;
  logic            sub;
  logic [XLEN-1:0] b_op;
  logic [XLEN:0]   sum;
  logic            lt_s;
  logic            lt_u;
  logic [XLEN-1:0] sh_res;
  logic [XLEN-1:0] res;
  logic            unused_clk;

  // clk is part of the uniform stage interface; nothing here is clocked
  assign unused_clk = clk;

  assign op = decode_sel(selector);

  // SUB and both compares run the adder as in0 + ~in1 + 1
  assign sub  = (op == OP_SUB) | (op == OP_SLT) | (op == OP_SLTU);
  assign b_op = sub ? ~in1 : in1;
  assign sum  = {1'b0, in0} + {1'b0, b_op} + {{XLEN{1'b0}}, sub};

  // unsigned borrow is the inverted carry; signed compare resolves overflow
  // by taking in0's sign when operand signs differ
  assign lt_u = ~sum[XLEN];
  assign lt_s = (in0[XLEN-1] != in1[XLEN-1]) ? in0[XLEN-1] : sum[XLEN-1];

  alu_shifter u_shifter (
    .data   (in0),
    .shamt  (in1[SHAMTW-1:0]),
    .dir    (op != OP_SLL),
    .arith  (op == OP_SRA),
    .result (sh_res)
  );

  // result mux; illegal selectors fall through to zero
  always_comb begin
    res = '0;
    case (op)
      OP_ADD, OP_SUB:         res = sum[XLEN-1:0];
      OP_SLL, OP_SRL, OP_SRA: res = sh_res;
      OP_SLT:                 res = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU:                res = {{(XLEN-1){1'b0}}, lt_u};
      OP_XOR:                 res = in0 ^ in1;
      OP_OR:                  res = in0 | in1;
      OP_AND:                 res = in0 & in1;
      default:                res = '0;
    endcase
  end

  // level-sensitive reset masks the result; zero always tracks out0
  always_comb begin
    out0 = rst ? '0 : res;
    zero = ~|out0;
  end

endmodule

// File: tb/tb_alu.sv
// Directed vector bench for the ALU plus reset sequencing checks.
module tb_alu;
  import alu_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] in0, in1;
  logic [9:0]  selector;
  logic [31:0] out0;
  logic        zero;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [9:0]  sel;
    logic [31:0] exp_out;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[$];

  alu dut (
    .clk      (clk),
    .rst      (rst),
    .in0      (in0),
    .in1      (in1),
    .selector (selector),
    .out0     (out0),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] eo, input logic ez);
    n_cmp++;
    if (out0 !== eo) begin
      n_bad++;
      $display("FAIL %s out0: got %h want %h", name, out0, eo);
    end
    n_cmp++;
    if (zero !== ez) begin
      n_bad++;
      $display("FAIL %s zero: got %b want %b", name, zero, ez);
    end
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [9:0] s);
    @(negedge clk);
    in0 = a; in1 = b; selector = s;
    #1;
  endtask

  initial begin
    vecs.push_back('{"add",       32'd5,          32'd5,          10'h000, 32'd10,         1'b0});
    vecs.push_back('{"and",       32'd6,          32'd2,          10'h007, 32'd2,          1'b0});
    vecs.push_back('{"sll",       32'd5,          32'd1,          10'h001, 32'd10,         1'b0});
    vecs.push_back('{"xor",       32'd1,          32'd1,          10'h004, 32'd0,          1'b1});
    vecs.push_back('{"sub_neg",   32'd3,          32'd5,          10'h100, 32'hFFFF_FFFE,  1'b0});
    vecs.push_back('{"sub_eq",    32'd5,          32'd5,          10'h100, 32'd0,          1'b1});
    vecs.push_back('{"sra31",     32'h8000_0000,  32'd31,         10'h105, 32'hFFFF_FFFF,  1'b0});
    vecs.push_back('{"sra_pos",   32'h7FFF_FFF0,  32'd4,          10'h105, 32'h07FF_FFFF,  1'b0});
    vecs.push_back('{"sra0",      32'hDEAD_BEEF,  32'd0,          10'h105, 32'hDEAD_BEEF,  1'b0});
    vecs.push_back('{"srl4",      32'h8000_0000,  32'd4,          10'h005, 32'h0800_0000,  1'b0});
    vecs.push_back('{"srl0",      32'hDEAD_BEEF,  32'd0,          10'h005, 32'hDEAD_BEEF,  1'b0});
    vecs.push_back('{"sll0_hi",   32'h1234_5678,  32'hFFFF_FFE0,  10'h001, 32'h1234_5678,  1'b0});
    vecs.push_back('{"sll_hi",    32'd1,          32'h0000_0021,  10'h001, 32'd2,          1'b0});
    vecs.push_back('{"sll31",     32'd1,          32'd31,         10'h001, 32'h8000_0000,  1'b0});
    vecs.push_back('{"slt_m1_1",  32'hFFFF_FFFF,  32'd1,          10'h002, 32'd1,          1'b0});
    vecs.push_back('{"slt_1_m1",  32'd1,          32'hFFFF_FFFF,  10'h002, 32'd0,          1'b1});
    vecs.push_back('{"slt_ovf",   32'h8000_0000,  32'h7FFF_FFFF,  10'h002, 32'd1,          1'b0});
    vecs.push_back('{"sltu_max",  32'hFFFF_FFFF,  32'd1,          10'h003, 32'd0,          1'b1});
    vecs.push_back('{"sltu_1",    32'd1,          32'hFFFF_FFFF,  10'h003, 32'd1,          1'b0});
    vecs.push_back('{"sltu_eq",   32'd7,          32'd7,          10'h003, 32'd0,          1'b1});
    vecs.push_back('{"add_wrap",  32'hFFFF_FFFF,  32'd1,          10'h000, 32'd0,          1'b1});
    vecs.push_back('{"or",        32'h0000_00F0,  32'h0000_000F,  10'h006, 32'h0000_00FF,  1'b0});
    vecs.push_back('{"ill_f7_01", 32'd5,          32'd5,          10'h008, 32'd0,          1'b1});
    vecs.push_back('{"ill_alt1",  32'd1,          32'd3,          10'h101, 32'd0,          1'b1});
    vecs.push_back('{"ill_ones",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  10'h3FF, 32'd0,          1'b1});

    rst = 1'b1; in0 = '0; in1 = '0; selector = '0;

    // reset held with an ADD 5+5 applied
    apply(32'd5, 32'd5, SEL_ADD);
    check("rst_add", 32'd0, 1'b1);
    apply(32'hFFFF_0000, 32'h0000_1234, SEL_OR);
    check("rst_or", 32'd0, 1'b1);
    apply(32'd5, 32'd5, SEL_ADD);
    // release: output follows inputs with no clock edge needed
    rst = 1'b0;
    #1;
    check("rst_release", 32'd10, 1'b0);

    foreach (vecs[i]) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].sel);
      check(vecs[i].name, vecs[i].exp_out, vecs[i].exp_zero);
    end

    // asynchronous reset assertion mid-operation, then release
    apply(32'h0000_00F0, 32'h0000_000F, SEL_XOR);
    check("pre_rst_xor", 32'h0000_00FF, 1'b0);
    #1 rst = 1'b1;
    #1 check("async_rst", 32'd0, 1'b1);
    #1 rst = 1'b0;
    #1 check("async_rel", 32'h0000_00FF, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
